// File: rtl/pit_table.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : pit_table                                                        |
// | Desc   : Pending Interest Table ahead of the FIB; aggregates interests,   |
// |          matches returning data to pending entries, ages stale entries.   |
// | Rev    : 1.0  initial release                                             |
// +--------------------------------------------------------------------------+
module pit_table #(
  parameter int DEPTH    = 4,
  parameter int PREFIX_W = 64,
  parameter int LEN_W    = 6,
  parameter int LIFETIME = 200
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   int_valid,
  output logic                   int_ready,
  input  logic [PREFIX_W-1:0]    int_prefix,
  input  logic [LEN_W-1:0]       int_len,
  output logic                   int_dup,
  output logic                   int_nack,
  output logic                   fib_send,
  output logic [PREFIX_W-1:0]    fib_prefix,
  output logic [LEN_W-1:0]       fib_len,
  input  logic                   fib_accept,
  input  logic                   fib_rejected,
  input  logic                   hdr_valid,
  output logic                   hdr_ready,
  input  logic [PREFIX_W-1:0]    hdr_prefix,
  input  logic [LEN_W-1:0]       hdr_len,
  input  logic                   byte_valid,
  output logic                   byte_ready,
  input  logic [7:0]             byte_in,
  input  logic                   byte_last,
  output logic                   out_valid,
  output logic [7:0]             out_byte,
  output logic                   out_last,
  output logic                   expired,
  output logic [$clog2(DEPTH):0] pit_count
);

  localparam int         c_IDX_W = $clog2(DEPTH);
  localparam int         c_CNT_W = $clog2(DEPTH) + 1;
  localparam logic [7:0] c_LIFE  = 8'(LIFETIME);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_INT_LOOKUP  = 3'd1,
    S_FIB_SEND    = 3'd2,
    S_FIB_WAIT    = 3'd3,
    S_DATA_LOOKUP = 3'd4,
    S_DATA_FWD    = 3'd5,
    S_DATA_DROP   = 3'd6
  } state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_live;
  logic [DEPTH-1:0]      r_valid, w_valid_nxt;
  logic [PREFIX_W-1:0]   r_ent_prefix [DEPTH];
  logic [LEN_W-1:0]      r_ent_len    [DEPTH];
  logic [7:0]            r_timer      [DEPTH];
  logic [7:0]            w_timer_nxt  [DEPTH];
  logic [PREFIX_W-1:0]   r_key_prefix;
  logic [LEN_W-1:0]      r_key_len;
  logic [c_IDX_W-1:0]    r_sel_idx;
  logic [PREFIX_W-1:0]   r_fib_prefix;
  logic [LEN_W-1:0]      r_fib_len;
  logic                  r_out_valid, r_out_last, r_expired;
  logic [7:0]            r_out_byte;
  logic [c_CNT_W-1:0]    r_count, w_count_nxt;

  logic [DEPTH-1:0]      w_match, w_refresh, w_alloc, w_consume, w_release, w_frozen;
  logic                  w_hit, w_free, w_expire_any, w_fib_busy, w_idle_rdy;
  logic [c_IDX_W-1:0]    w_hit_idx, w_free_idx;
  logic                  w_hdr_acc, w_int_acc, w_byte_acc, w_fwd_acc;

  // r_live keeps the handshakes closed while reset is held and for the first edge after it.
  assign w_idle_rdy = r_live && (r_state == S_IDLE);
  assign hdr_ready  = w_idle_rdy;
  assign int_ready  = w_idle_rdy && !hdr_valid;
  assign byte_ready = (r_state == S_DATA_FWD) || (r_state == S_DATA_DROP);
  assign w_hdr_acc  = hdr_valid && hdr_ready;
  assign w_int_acc  = int_valid && int_ready;
  assign w_byte_acc = byte_valid && byte_ready;
  assign w_fwd_acc  = w_byte_acc && (r_state == S_DATA_FWD);
  assign w_fib_busy = (r_state == S_FIB_SEND) || (r_state == S_FIB_WAIT);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    assign w_match[gi]   = r_valid[gi] && (r_ent_prefix[gi] == r_key_prefix) &&
                           (r_ent_len[gi] == r_key_len);
    assign w_refresh[gi] = (r_state == S_INT_LOOKUP) && w_hit && (w_hit_idx == c_IDX_W'(gi));
    assign w_alloc[gi]   = (r_state == S_INT_LOOKUP) && !w_hit && w_free &&
                           (w_free_idx == c_IDX_W'(gi));
    assign w_consume[gi] = (r_state == S_DATA_LOOKUP) && w_hit && (w_hit_idx == c_IDX_W'(gi));
    assign w_release[gi] = (r_state == S_FIB_WAIT) && fib_rejected && (r_sel_idx == c_IDX_W'(gi));
    assign w_frozen[gi]  = w_fib_busy && (r_sel_idx == c_IDX_W'(gi));
  end

  // Descending scan so the lowest index wins.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_free     = 1'b0;
    w_free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_hit     = 1'b1;
        w_hit_idx = c_IDX_W'(i);
      end
      if (!r_valid[i]) begin
        w_free     = 1'b1;
        w_free_idx = c_IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    int_dup     = 1'b0;
    int_nack    = 1'b0;
    fib_send    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_hdr_acc)      w_state_nxt = S_DATA_LOOKUP;
        else if (w_int_acc) w_state_nxt = S_INT_LOOKUP;
      end
      S_INT_LOOKUP: begin
        int_dup     = w_hit;
        int_nack    = !w_hit && !w_free;
        w_state_nxt = (!w_hit && w_free) ? S_FIB_SEND : S_IDLE;
      end
      S_FIB_SEND: begin
        fib_send    = 1'b1;
        w_state_nxt = S_FIB_WAIT;
      end
      S_FIB_WAIT: begin
        int_nack = fib_rejected;
        if (fib_rejected || fib_accept) w_state_nxt = S_IDLE;
      end
      S_DATA_LOOKUP: w_state_nxt = w_hit ? S_DATA_FWD : S_DATA_DROP;
      S_DATA_FWD, S_DATA_DROP: begin
        if (w_byte_acc && byte_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Lookup actions take priority over ageing, so a last-cycle refresh or hit never expires.
  always_comb begin
    w_valid_nxt  = r_valid;
    w_expire_any = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_timer_nxt[i] = r_timer[i];
      if (w_refresh[i] || w_alloc[i]) begin
        w_valid_nxt[i] = 1'b1;
        w_timer_nxt[i] = c_LIFE;
      end else if (w_consume[i] || w_release[i]) begin
        w_valid_nxt[i] = 1'b0;
        w_timer_nxt[i] = '0;
      end else if (r_valid[i] && !w_frozen[i]) begin
        if (r_timer[i] == 8'd1) begin
          w_valid_nxt[i] = 1'b0;
          w_timer_nxt[i] = '0;
          w_expire_any   = 1'b1;
        end else begin
          w_timer_nxt[i] = r_timer[i] - 8'd1;
        end
      end
    end
  end

  always_comb begin
    w_count_nxt = '0;
    for (int i = 0; i < DEPTH; i++) w_count_nxt = w_count_nxt + c_CNT_W'(w_valid_nxt[i]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_live       <= 1'b0;
      r_valid      <= '0;
      for (int i = 0; i < DEPTH; i++) r_timer[i] <= '0;
      r_key_prefix <= '0;
      r_key_len    <= '0;
      r_sel_idx    <= '0;
      r_fib_prefix <= '0;
      r_fib_len    <= '0;
      r_out_valid  <= 1'b0;
      r_out_byte   <= '0;
      r_out_last   <= 1'b0;
      r_expired    <= 1'b0;
      r_count      <= '0;
    end else begin
      r_live  <= 1'b1;
      r_valid <= w_valid_nxt;
      for (int i = 0; i < DEPTH; i++) r_timer[i] <= w_timer_nxt[i];
      if (w_hdr_acc) begin
        r_key_prefix <= hdr_prefix;
        r_key_len    <= hdr_len;
      end else if (w_int_acc) begin
        r_key_prefix <= int_prefix;
        r_key_len    <= int_len;
      end
      if ((r_state == S_INT_LOOKUP) && !w_hit && w_free) begin
        r_sel_idx    <= w_free_idx;
        r_fib_prefix <= r_key_prefix;
        r_fib_len    <= r_key_len;
      end
      r_out_valid <= w_fwd_acc;
      r_out_last  <= w_fwd_acc && byte_last;
      if (w_fwd_acc) r_out_byte <= byte_in;
      r_expired <= w_expire_any;
      r_count   <= w_count_nxt;
    end
  end

  // Key storage is qualified by r_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_alloc[i]) begin
        r_ent_prefix[i] <= r_key_prefix;
        r_ent_len[i]    <= r_key_len;
      end
    end
  end

  assign fib_prefix = r_fib_prefix;
  assign fib_len    = r_fib_len;
  assign out_valid  = r_out_valid;
  assign out_byte   = r_out_byte;
  assign out_last   = r_out_last;
  assign expired    = r_expired;
  assign pit_count  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_pit_table.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for pit_table: directed plan steps followed by randomized traffic,
// checked against a deadline-based model of the pending table.
module tb_pit_table;
  localparam int DEPTH = 4;
  localparam int LIFE  = 200;
  localparam int FROZEN = 32'h3fff_ffff;

  logic clk = 1'b0;
  logic rst;
  logic int_valid, int_ready, int_dup, int_nack;
  logic [63:0] int_prefix, fib_prefix, hdr_prefix;
  logic [5:0] int_len, fib_len, hdr_len;
  logic fib_send, fib_accept, fib_rejected;
  logic hdr_valid, hdr_ready, byte_valid, byte_ready, byte_last;
  logic [7:0] byte_in, out_byte;
  logic out_valid, out_last, expired;
  logic [2:0] pit_count;

  always #5 clk = ~clk;

  pit_table #(.DEPTH(DEPTH), .PREFIX_W(64), .LEN_W(6), .LIFETIME(LIFE)) dut (
    .clk(clk), .rst(rst),
    .int_valid(int_valid), .int_ready(int_ready), .int_prefix(int_prefix), .int_len(int_len),
    .int_dup(int_dup), .int_nack(int_nack),
    .fib_send(fib_send), .fib_prefix(fib_prefix), .fib_len(fib_len),
    .fib_accept(fib_accept), .fib_rejected(fib_rejected),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_prefix(hdr_prefix), .hdr_len(hdr_len),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_in(byte_in), .byte_last(byte_last),
    .out_valid(out_valid), .out_byte(out_byte), .out_last(out_last),
    .expired(expired), .pit_count(pit_count)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  // Model: an entry is live in cycle t while t < its deadline; it expires in cycle == deadline.
  bit          m_valid [DEPTH];
  logic [63:0] m_pfx   [DEPTH];
  logic [5:0]  m_len   [DEPTH];
  int          m_dl    [DEPTH];

  function automatic bit alive(input int i);
    return m_valid[i] && (m_dl[i] > cyc);
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (alive(i)) n++;
    return n;
  endfunction

  function automatic bit model_expired();
    for (int i = 0; i < DEPTH; i++) if (m_valid[i] && m_dl[i] == cyc) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int find_hit(input logic [63:0] p, input logic [5:0] l);
    for (int i = 0; i < DEPTH; i++) if (alive(i) && m_pfx[i] == p && m_len[i] == l) return i;
    return -1;
  endfunction

  function automatic int find_free();
    for (int i = 0; i < DEPTH; i++) if (!alive(i)) return i;
    return -1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cycle();
    chk("expired", expired, model_expired());
    chk("pit_count", pit_count, model_count());
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      #1;
      check_cycle();
      tick();
    end
  endtask

  // resp: 0 accept, 1 reject, 2 both (reject wins)
  task automatic do_interest(input logic [63:0] p, input logic [5:0] l, input int resp, input int dly);
    int h, f, lk;
    int_valid = 1'b1; int_prefix = p; int_len = l;
    #1;
    chk("int_ready", int_ready, 1);
    check_cycle();
    tick();
    int_valid = 1'b0;
    #1;
    lk = cyc;
    h  = find_hit(p, l);
    f  = find_free();
    chk("int_dup", int_dup, h >= 0);
    chk("int_nack_full", int_nack, (h < 0) && (f < 0));
    chk("fib_send_early", fib_send, 0);
    check_cycle();
    if (h >= 0) m_dl[h] = lk + 1 + LIFE;
    else if (f >= 0) begin
      m_valid[f] = 1'b1; m_pfx[f] = p; m_len[f] = l; m_dl[f] = FROZEN;
    end
    tick();
    if (h < 0 && f >= 0) begin
      #1;
      chk("fib_send", fib_send, 1);
      chk("fib_prefix", fib_prefix, p);
      chk("fib_len", fib_len, l);
      check_cycle();
      tick();
      repeat (dly) begin
        #1;
        chk("fib_send_once", fib_send, 0);
        chk("int_nack_wait", int_nack, 0);
        check_cycle();
        tick();
      end
      fib_accept = (resp != 1); fib_rejected = (resp != 0);
      #1;
      chk("int_nack_fib", int_nack, resp != 0);
      check_cycle();
      if (resp != 0) m_valid[f] = 1'b0;
      else           m_dl[f] = cyc + 1 + LIFE;
      tick();
      fib_accept = 1'b0; fib_rejected = 1'b0;
    end
  endtask

  task automatic do_data(input logic [63:0] p, input logic [5:0] l, input int nb,
                         input logic [7:0] seed, input bit with_int);
    int h, sent, guard;
    bit v, pacc, plast;
    logic [7:0] pb, b;
    hdr_valid = 1'b1; hdr_prefix = p; hdr_len = l;
    if (with_int) begin int_valid = 1'b1; int_prefix = ~p; int_len = l; end
    #1;
    chk("hdr_ready", hdr_ready, 1);
    if (with_int) chk("int_ready_blocked", int_ready, 0);
    check_cycle();
    tick();
    hdr_valid = 1'b0; int_valid = 1'b0;
    #1;
    h = find_hit(p, l);
    chk("data_lookup_quiet", {int_dup, int_nack, byte_ready}, 0);
    check_cycle();
    if (h >= 0) m_valid[h] = 1'b0;
    tick();
    sent = 0; guard = 0; pacc = 1'b0; plast = 1'b0; pb = '0;
    while (sent < nb && guard < 400) begin
      guard++;
      v = ($urandom_range(0, 3) != 0);
      b = seed + 8'(sent * 17);
      byte_valid = v; byte_in = b; byte_last = (sent == nb - 1);
      #1;
      chk("byte_ready", byte_ready, 1);
      chk("out_valid", out_valid, (h >= 0) && pacc);
      if (h >= 0 && pacc) begin
        chk("out_byte", out_byte, pb);
        chk("out_last", out_last, plast);
      end
      check_cycle();
      pacc = v; pb = b; plast = (sent == nb - 1);
      if (v) sent++;
      tick();
    end
    byte_valid = 1'b0; byte_last = 1'b0;
    #1;
    chk("out_valid_final", out_valid, h >= 0);
    if (h >= 0) begin
      chk("out_byte_final", out_byte, pb);
      chk("out_last_final", out_last, 1);
    end
    chk("byte_ready_idle", byte_ready, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [63:0] pool [6];
  int h, dl, op, k;
  logic [5:0] ln;

  initial begin
    rst = 1'b0;
    int_valid = 0; int_prefix = '0; int_len = '0;
    fib_accept = 0; fib_rejected = 0;
    hdr_valid = 0; hdr_prefix = '0; hdr_len = '0;
    byte_valid = 0; byte_in = '0; byte_last = 0;
    model_clear();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", {int_ready, hdr_ready, byte_ready, fib_send, int_dup, int_nack,
                     out_valid, out_last, expired}, 0);
    chk("rst_fib_prefix", fib_prefix, 0);
    chk("rst_fib_len", fib_len, 0);
    chk("rst_out_byte", out_byte, 0);
    chk("rst_pit_count", pit_count, 0);
    rst = 1'b1;
    tick();

    // New interest, then the same one again while pending
    do_interest(64'hA5A5_0000_0000_0001, 6'd16, 0, 0);
    idle_cycles(2);
    do_interest(64'hA5A5_0000_0000_0001, 6'd16, 0, 0);

    // Fill the table, fifth distinct interest is refused
    do_interest(64'hA5A5_0000_0000_0002, 6'd16, 0, 1);
    do_interest(64'hA5A5_0000_0000_0003, 6'd16, 0, 0);
    do_interest(64'hA5A5_0000_0000_0001, 6'd17, 0, 2);
    do_interest(64'hA5A5_0000_0000_0005, 6'd16, 0, 0);
    idle_cycles(LIFE + 5);

    // FIB reject, and accept+reject together
    do_interest(64'hBEEF, 6'd20, 1, 1);
    do_interest(64'hBEEF, 6'd20, 2, 0);

    // Data hit with three bytes, then the same header misses
    do_interest(64'h1, 6'd8, 0, 2);
    do_data(64'h1, 6'd8, 3, 8'h11, 1'b0);
    do_data(64'h1, 6'd8, 3, 8'h11, 1'b0);

    // Plain ageing, then refresh and data hit on an entry's final live cycle
    do_interest(64'hC0DE_0000_0000_0007, 6'd32, 0, 0);
    idle_cycles(LIFE + 3);
    do_interest(64'hC0DE_0000_0000_0008, 6'd32, 0, 0);
    h = find_hit(64'hC0DE_0000_0000_0008, 6'd32);
    dl = m_dl[h];
    while (cyc < dl - 2) idle_cycles(1);
    do_interest(64'hC0DE_0000_0000_0008, 6'd32, 0, 0);
    h = find_hit(64'hC0DE_0000_0000_0008, 6'd32);
    dl = m_dl[h];
    while (cyc < dl - 2) idle_cycles(1);
    do_data(64'hC0DE_0000_0000_0008, 6'd32, 2, 8'h70, 1'b0);
    idle_cycles(3);

    // Header and interest offered together: header served first
    do_interest(64'h0F0F_F0F0_1234_5678, 6'd24, 0, 1);
    do_data(64'h0F0F_F0F0_1234_5678, 6'd24, 2, 8'h40, 1'b1);

    // Reset in the middle of forwarding
    do_interest(64'hDEAD_BEEF_0000_0042, 6'd12, 0, 0);
    hdr_valid = 1'b1; hdr_prefix = 64'hDEAD_BEEF_0000_0042; hdr_len = 6'd12;
    #1; check_cycle(); tick();
    hdr_valid = 1'b0;
    #1;
    h = find_hit(64'hDEAD_BEEF_0000_0042, 6'd12);
    check_cycle();
    if (h >= 0) m_valid[h] = 1'b0;
    tick();
    byte_valid = 1'b1; byte_in = 8'h5A; byte_last = 1'b0;
    #1; chk("fwd_byte_ready", byte_ready, 1); check_cycle(); tick();
    byte_valid = 1'b0;
    #1;
    chk("fwd_out_valid", out_valid, 1);
    chk("fwd_out_byte", out_byte, 8'h5A);
    rst = 1'b0;
    #1;
    chk("midrst_ctrl", {int_ready, hdr_ready, byte_ready, fib_send, int_dup, int_nack,
                        out_valid, out_last, expired}, 0);
    chk("midrst_out_byte", out_byte, 0);
    chk("midrst_pit_count", pit_count, 0);
    model_clear();
    tick();
    rst = 1'b1;
    tick();
    chk("postrst_idle", {hdr_ready, int_ready, byte_ready}, 3'b110);

    // Randomized traffic over a small key pool so hits, duplicates and a full table occur
    for (int i = 0; i < 6; i++) pool[i] = {$urandom, $urandom};
    for (int t = 0; t < 70; t++) begin
      op = $urandom_range(0, 9);
      k  = $urandom_range(0, 5);
      ln = ($urandom_range(0, 1) != 0) ? 6'd8 : 6'd16;
      if (op < 5)
        do_interest(pool[k], ln, $urandom_range(0, 2), $urandom_range(0, 3));
      else if (op < 8)
        do_data(pool[k], ln, $urandom_range(1, 4), 8'($urandom), $urandom_range(0, 5) == 0);
      else
        idle_cycles((op == 9) ? $urandom_range(120, 260) : $urandom_range(1, 6));
    end
    idle_cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
